// File: rtl/scope_capture_ctrl_if.sv
// scope_capture_ctrl_if: front-panel/trigger inputs and sample-bank write bus of the capture sequencer
interface scope_capture_ctrl_if;
  logic       trig_in;
  logic       vsync;
  logic       run;
  logic       start;
  logic       abort;
  logic       auto_en;
  logic [2:0] tb_sel;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       wr_bank;
  logic       disp_bank;
  logic       frame_ready;
  logic       auto_trig;
  logic       busy;
  modport master (
    input  trig_in, vsync, run, start, abort, auto_en, tb_sel,
    output wr_en, wr_addr, wr_bank, disp_bank, frame_ready, auto_trig, busy
  );
  modport slave (
    output trig_in, vsync, run, start, abort, auto_en, tb_sel,
    input  wr_en, wr_addr, wr_bank, disp_bank, frame_ready, auto_trig, busy
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: trigger/auto-armed capture sequencer writing ping-pong sample banks
module scope_capture_ctrl #(
  parameter int DEPTH   = 200,
  parameter int AUTO_TO = 5_000_000,
  parameter int HOLDOFF = 1000
) (
  input logic clk,
  input logic rst_n,
  scope_capture_ctrl_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
  localparam int TW = $clog2(AUTO_TO + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(AUTO_TO - 1);
  localparam logic [HW-1:0] HO_END = HW'(HOLDOFF);
  localparam logic [7:0] LAST = 8'(DEPTH - 1);
  localparam logic [7:0] N_TAB [8] = '{8'd1, 8'd2, 8'd5, 8'd10, 8'd20, 8'd50, 8'd100, 8'd200};
  logic [1:0]    state;
  logic [2:0]    ts;
  logic          trig_rise, vs_d, vs_rise, by_run, cap_auto, go_trig, go_auto;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] ho_cnt;
  logic [7:0]    n_val, div;
  always_comb begin
    go_trig       = trig_rise && ho_cnt == HO_END;
    go_auto       = bus.auto_en && to_cnt == TO_LAST;
    bus.wr_en     = state == CAPTURE && div == 8'd0;
    bus.busy      = state != IDLE;
    bus.disp_bank = ~bus.wr_bank;
  end
  // holdoff/timeout counters run only in ARM and sit at zero elsewhere, so every ARM entry starts them fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ts              <= '0;
      trig_rise       <= 1'b0;
      vs_d            <= 1'b0;
      vs_rise         <= 1'b0;
      by_run          <= 1'b0;
      cap_auto        <= 1'b0;
      to_cnt          <= '0;
      ho_cnt          <= '0;
      n_val           <= 8'd1;
      div             <= '0;
      bus.wr_addr     <= '0;
      bus.wr_bank     <= 1'b0;
      bus.frame_ready <= 1'b0;
      bus.auto_trig   <= 1'b0;
    end else begin
      ts              <= {ts[1:0], bus.trig_in};
      trig_rise       <= ts[1] & ~ts[2];
      vs_d            <= bus.vsync;
      vs_rise         <= bus.vsync & ~vs_d;
      bus.frame_ready <= 1'b0;
      ho_cnt <= state == ARM ? (ho_cnt == HO_END ? ho_cnt : ho_cnt + HW'(1)) : '0;
      to_cnt <= state == ARM ? (to_cnt == TO_LAST ? to_cnt : to_cnt + TW'(1)) : '0;
      if (bus.abort) begin
        state       <= IDLE;
        bus.wr_addr <= '0;
      end else if (state == IDLE) begin
        if (bus.run || bus.start) begin
          state  <= ARM;
          by_run <= ~bus.start;
        end
      end else if (state == ARM) begin
        if (go_trig || go_auto) begin
          state       <= CAPTURE;
          cap_auto    <= ~go_trig;
          n_val       <= N_TAB[bus.tb_sel];
          div         <= '0;
          bus.wr_addr <= '0;
        end else if (by_run && !bus.run) begin
          state <= IDLE;
        end
      end else if (state == CAPTURE) begin
        div <= div == n_val - 8'd1 ? 8'd0 : div + 8'd1;
        if (bus.wr_en) begin
          if (bus.wr_addr == LAST) state <= DONE;
          else bus.wr_addr <= bus.wr_addr + 8'd1;
        end
      end else if (vs_rise) begin
        bus.wr_bank     <= ~bus.wr_bank;
        bus.auto_trig   <= cap_auto;
        bus.frame_ready <= 1'b1;
        by_run          <= 1'b1;
        state           <= bus.run ? ARM : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: scoreboard bench for the capture sequencer (write stream and bank swaps)
module tb_scope_capture_ctrl;
  localparam int DEPTH = 200, AUTO_TO = 3000, HOLDOFF = 40;
  typedef struct {int addr; int bank; int gap;} wr_t;
  typedef struct {int cyc; int bank; int auto_t;} fr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wr_t wq[$];
  fr_t fq[$];
  int cyc = 0, last_wr = 0, n_chk = 0, n_err = 0, bank = 0, f = 0;
  scope_capture_ctrl_if bus();
  scope_capture_ctrl #(.DEPTH(DEPTH), .AUTO_TO(AUTO_TO), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    wr_t w;
    fr_t r;
    if (bus.wr_en === 1'b1) begin
      if (wq.size() == 0) check("wr_unexpected_addr", int'(bus.wr_addr), -1);
      else begin
        w = wq.pop_front();
        check("wr_addr", int'(bus.wr_addr), w.addr);
        check("wr_bank", int'(bus.wr_bank), w.bank);
        if (w.gap != 0) check("wr_gap", cyc - last_wr, w.gap);
      end
      last_wr = cyc;
    end
    if (bus.frame_ready === 1'b1) begin
      if (fq.size() == 0) check("frame_unexpected_bank", int'(bus.wr_bank), -1);
      else begin
        r = fq.pop_front();
        check("frame_cycle", cyc, r.cyc);
        check("frame_wr_bank", int'(bus.wr_bank), r.bank);
        check("frame_disp_bank", int'(bus.disp_bank), 1 - r.bank);
        check("frame_auto_trig", int'(bus.auto_trig), r.auto_t);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask
  task automatic push_rec(input int b, input int n, input int cnt, input int first_gap);
    for (int i = 0; i < cnt; i++) wq.push_back('{i, b, i == 0 ? first_gap : n});
  endtask
  task automatic trigger();
    bus.trig_in = 1'b1;
    last_wr = cyc;
    tick();
    bus.trig_in = 1'b0;
  endtask
  task automatic wait_done(input int bound);
    int k = 0;
    while (wq.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    if (wq.size() != 0) begin
      check("record_timeout_left", wq.size(), 0);
      wq.delete();
    end
  endtask
  task automatic swap(input int au, output int fc);
    fc = cyc + 2;
    fq.push_back('{fc, 1 - bank, au});
    bank = 1 - bank;
    bus.vsync = 1'b1;
    tick(3);
    bus.vsync = 1'b0;
    check("frame_pending", fq.size(), 0);
    fq.delete();
    check("bank_after_swap", int'(bus.wr_bank), bank);
  endtask
  task automatic wait_addr(input int a, input int bound);
    int k = 0;
    while (int'(bus.wr_addr) != a && k < bound) begin
      tick();
      k++;
    end
    check("wait_wr_addr", int'(bus.wr_addr), a);
  endtask
  task automatic check_reset_outputs(input string p);
    check({p, "_wr_en"}, int'(bus.wr_en), 0);
    check({p, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({p, "_wr_bank"}, int'(bus.wr_bank), 0);
    check({p, "_disp_bank"}, int'(bus.disp_bank), 1);
    check({p, "_frame_ready"}, int'(bus.frame_ready), 0);
    check({p, "_auto_trig"}, int'(bus.auto_trig), 0);
    check({p, "_busy"}, int'(bus.busy), 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    {bus.trig_in, bus.vsync, bus.run, bus.start, bus.abort, bus.auto_en} = '0;
    bus.tb_sel = 3'd0;
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", int'(bus.busy), 0);
    // continuous run, N=1, manual trigger after holdoff
    bus.run = 1'b1;
    tick();
    check("arm_busy", int'(bus.busy), 1);
    tick(HOLDOFF + 5);
    push_rec(bank, 1, DEPTH, 4);
    trigger();
    wait_done(400);
    swap(0, f);
    check("rearm_busy", int'(bus.busy), 1);
    // N=10, timebase change mid-record must not affect spacing
    wait_cyc(f + HOLDOFF + 5);
    bus.tb_sel = 3'd3;
    push_rec(bank, 10, DEPTH, 4);
    trigger();
    tick(100);
    bus.tb_sel = 3'd0;
    wait_done(2500);
    swap(0, f);
    // holdoff: edges at ho_cnt=5 and HOLDOFF-2 ignored, edge at HOLDOFF accepted
    wait_cyc(f + 2);
    bus.trig_in = 1'b1;
    tick(3);
    bus.trig_in = 1'b0;
    wait_cyc(f + HOLDOFF - 5);
    bus.trig_in = 1'b1;
    tick();
    bus.trig_in = 1'b0;
    tick();
    push_rec(bank, 1, DEPTH, 4);
    trigger();
    wait_done(400);
    // auto trigger with N=2, entering ARM at the next swap
    bus.auto_en = 1'b1;
    bus.tb_sel = 3'd1;
    swap(0, f);
    last_wr = f;
    push_rec(bank, 2, DEPTH, AUTO_TO);
    wait_done(AUTO_TO + 600);
    bus.auto_en = 1'b0;
    swap(1, f);
    check("auto_trig_level", int'(bus.auto_trig), 1);
    tick(2 * AUTO_TO);
    check("no_auto_busy", int'(bus.busy), 1);
    check("no_auto_addr_hold", int'(bus.wr_addr), DEPTH - 1);
    // run dropped in ARM, then single shot
    bus.run = 1'b0;
    tick(2);
    check("run_off_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_busy", int'(bus.busy), 1);
    tick(HOLDOFF + 5);
    bus.tb_sel = 3'd0;
    push_rec(bank, 1, DEPTH, 4);
    trigger();
    wait_done(400);
    swap(0, f);
    tick();
    check("single_idle_busy", int'(bus.busy), 0);
    check("single_auto_trig", int'(bus.auto_trig), 0);
    // abort with wr_addr=57
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(HOLDOFF + 5);
    bus.tb_sel = 3'd3;
    push_rec(bank, 10, 57, 4);
    trigger();
    wait_addr(57, 1000);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_wr_addr", int'(bus.wr_addr), 0);
    check("abort_wr_en", int'(bus.wr_en), 0);
    check("abort_left", wq.size(), 0);
    wq.delete();
    bus.vsync = 1'b1;
    tick(4);
    bus.vsync = 1'b0;
    tick(2);
    check("abort_no_swap", int'(bus.wr_bank), bank);
    // asynchronous reset mid-capture, then resume
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(HOLDOFF + 5);
    push_rec(bank, 10, 20, 4);
    trigger();
    wait_addr(20, 1000);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    bank = 0;
    check("midrst_left", wq.size(), 0);
    wq.delete();
    tick(2);
    rst_n = 1'b1;
    bus.tb_sel = 3'd0;
    bus.run = 1'b1;
    tick();
    tick(HOLDOFF + 5);
    push_rec(bank, 1, DEPTH, 4);
    trigger();
    wait_done(400);
    swap(0, f);
    bus.run = 1'b0;
    tick(5);
    check("end_wq_empty", wq.size(), 0);
    check("end_fq_empty", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
